// File: rtl/ct_mat_pkg.sv
// Shared types and constants for the matrix load row sequencer.
package ct_mat_pkg;

   localparam int unsigned ROW_BYTES    = 64;
   localparam int unsigned IID_WIDTH    = 7;
   localparam int unsigned TREG_WIDTH   = 3;
   localparam int unsigned SIZE_M_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CMPLT = 3'd3,
      ST_DRAIN = 3'd4
   } mat_ld_state_e;

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is captured while the clock is low so the
// gated clock never glitches.
module gated_clk_cell (
   input  logic i_clk_in,
   input  logic i_global_en,
   input  logic i_module_en,
   input  logic i_local_en,
   input  logic i_external_en,
   input  logic i_scan_en,
   output logic o_clk_out
);

   logic w_en_bf_latch;
   logic r_en_lat;

   assign w_en_bf_latch = (i_global_en & (i_module_en | i_local_en)) | i_external_en;

   always_latch begin
      if (!i_clk_in) begin
         r_en_lat <= w_en_bf_latch | i_scan_en;
      end
   end

   assign o_clk_out = i_clk_in & r_en_lat;

endmodule

// File: rtl/ct_mat_lsu_ld_row_seq.sv
// Splits one matrix tile load into per-row LSU requests, counts row responses
// and reports completion; flush aborts and drains outstanding responses.
module ct_mat_lsu_ld_row_seq
   import ct_mat_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int ROW_BYTES  = ct_mat_pkg::ROW_BYTES
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst_b,
   input  logic                    cp0_mat_icg_en,
   input  logic                    cp0_yy_clk_en,
   input  logic                    pad_yy_icg_scan_en,
   input  logic                    rtu_yy_xx_flush,
   input  logic [15:0]             x_sizeK,
   input  logic [7:0]              x_sizeM,
   input  logic                    idu_mat_rf_ld_sel,
   input  logic [IID_WIDTH-1:0]    idu_mat_rf_ld_iid,
   input  logic [ADDR_WIDTH-1:0]   idu_mat_rf_ld_base,
   input  logic [ADDR_WIDTH-1:0]   idu_mat_rf_ld_stride,
   input  logic [TREG_WIDTH-1:0]   idu_mat_rf_ld_treg,
   output logic                    mat_ld_idu_rf_ready,
   output logic                    mat_ld_lsu_req_vld,
   input  logic                    lsu_mat_ld_req_rdy,
   output logic [ADDR_WIDTH-1:0]   mat_ld_lsu_req_addr,
   output logic [6:0]              mat_ld_lsu_req_bytes,
   output logic [SIZE_M_WIDTH-1:0] mat_ld_lsu_req_row,
   output logic [TREG_WIDTH-1:0]   mat_ld_lsu_req_treg,
   input  logic                    lsu_mat_ld_resp_vld,
   output logic                    mat_ld_cbus_sel,
   output logic [IID_WIDTH-1:0]    mat_ld_cbus_iid
);

   mat_ld_state_e             r_state;
   mat_ld_state_e             w_state_nxt;
   logic [SIZE_M_WIDTH-1:0]   r_issue_cnt;
   logic [SIZE_M_WIDTH-1:0]   r_resp_cnt;
   logic [ADDR_WIDTH-1:0]     r_row_addr;
   logic [IID_WIDTH-1:0]      r_iid;
   logic [ADDR_WIDTH-1:0]     r_stride;
   logic [TREG_WIDTH-1:0]     r_treg;
   logic [SIZE_M_WIDTH-1:0]   r_size_m;
   logic [6:0]                r_size_k;

   logic                      w_accept;
   logic                      w_hs;
   logic                      w_resp;
   logic                      w_last_row;
   logic                      w_zero_size;
   logic [6:0]                w_size_k_in;
   logic [SIZE_M_WIDTH-1:0]   w_issue_nxt;
   logic [SIZE_M_WIDTH-1:0]   w_resp_nxt;
   logic                      w_ctrl_clk;
   logic                      w_snap_clk;
   logic                      w_ctrl_local_en;

   assign w_size_k_in = (x_sizeK > 16'(ROW_BYTES)) ? 7'(ROW_BYTES) : x_sizeK[6:0];
   assign w_zero_size = (x_sizeM == 8'd0) || (w_size_k_in == 7'd0);
   assign w_accept    = idu_mat_rf_ld_sel && (r_state == ST_IDLE) && !rtu_yy_xx_flush;
   assign w_hs        = mat_ld_lsu_req_vld && lsu_mat_ld_req_rdy;
   assign w_resp      = lsu_mat_ld_resp_vld &&
                        ((r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_DRAIN));
   assign w_issue_nxt = r_issue_cnt + {7'd0, w_hs};
   assign w_resp_nxt  = r_resp_cnt + {7'd0, w_resp};
   assign w_last_row  = (r_issue_cnt == (r_size_m - 8'd1));

   assign w_ctrl_local_en = idu_mat_rf_ld_sel || (r_state != ST_IDLE);

   gated_clk_cell u_ctrl_gate (
      .i_clk_in      (forever_cpuclk),
      .i_global_en   (cp0_yy_clk_en),
      .i_module_en   (cp0_mat_icg_en),
      .i_local_en    (w_ctrl_local_en),
      .i_external_en (1'b0),
      .i_scan_en     (pad_yy_icg_scan_en),
      .o_clk_out     (w_ctrl_clk)
   );

   gated_clk_cell u_snap_gate (
      .i_clk_in      (forever_cpuclk),
      .i_global_en   (cp0_yy_clk_en),
      .i_module_en   (cp0_mat_icg_en),
      .i_local_en    (w_accept),
      .i_external_en (1'b0),
      .i_scan_en     (pad_yy_icg_scan_en),
      .o_clk_out     (w_snap_clk)
   );

   // State register.
   always_ff @(posedge w_ctrl_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a flush drains any responses still owed by the LSU.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_zero_size ? ST_CMPLT : ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE, ST_WAIT, ST_CMPLT: begin
            if (rtu_yy_xx_flush) begin
               w_state_nxt = (w_issue_nxt != w_resp_nxt) ? ST_DRAIN : ST_IDLE;
            end else if (r_state == ST_CMPLT) begin
               w_state_nxt = ST_IDLE;
            end else if (r_state == ST_ISSUE) begin
               if (w_hs && w_last_row) begin
                  w_state_nxt = (w_resp_nxt == r_size_m) ? ST_CMPLT : ST_WAIT;
               end else begin
                  w_state_nxt = ST_ISSUE;
               end
            end else if (w_resp_nxt == r_size_m) begin
               w_state_nxt = ST_CMPLT;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (w_resp_nxt == r_issue_cnt) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode; flush suppresses requests and completion in the same cycle.
   always_comb begin
      mat_ld_idu_rf_ready = 1'b0;
      mat_ld_lsu_req_vld  = 1'b0;
      mat_ld_cbus_sel     = 1'b0;
      case (r_state)
         ST_IDLE:  mat_ld_idu_rf_ready = 1'b1;
         ST_ISSUE: mat_ld_lsu_req_vld  = !rtu_yy_xx_flush;
         ST_CMPLT: mat_ld_cbus_sel     = !rtu_yy_xx_flush;
         default:  mat_ld_idu_rf_ready = 1'b0;
      endcase
   end

   // Row/response counters and running row address.
   always_ff @(posedge w_ctrl_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_issue_cnt <= 8'd0;
         r_resp_cnt  <= 8'd0;
         r_row_addr  <= '0;
      end else if (w_accept) begin
         r_issue_cnt <= 8'd0;
         r_resp_cnt  <= 8'd0;
         r_row_addr  <= idu_mat_rf_ld_base;
      end else begin
         r_issue_cnt <= w_issue_nxt;
         r_resp_cnt  <= w_resp_nxt;
         if (w_hs) begin
            r_row_addr <= r_row_addr + r_stride;
         end
      end
   end

   // Instruction snapshot; its clock only ticks on accept.
   always_ff @(posedge w_snap_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_iid    <= '0;
         r_stride <= '0;
         r_treg   <= '0;
         r_size_m <= 8'd0;
         r_size_k <= 7'd0;
      end else begin
         r_iid    <= idu_mat_rf_ld_iid;
         r_stride <= idu_mat_rf_ld_stride;
         r_treg   <= idu_mat_rf_ld_treg;
         r_size_m <= x_sizeM;
         r_size_k <= w_size_k_in;
      end
   end

   assign mat_ld_lsu_req_addr  = r_row_addr;
   assign mat_ld_lsu_req_bytes = r_size_k;
   assign mat_ld_lsu_req_row   = r_issue_cnt;
   assign mat_ld_lsu_req_treg  = r_treg;
   assign mat_ld_cbus_iid      = r_iid;

endmodule
